// File: rtl/wave_pkg.sv
// wave_pkg: shared definitions for the waveform amplitude scaler.
//   DEF_DATA_W : default sample width used by wave_shift_pipe / wave_shift_core
//   mode_e     : shift mode encoding carried through the pipeline
package wave_pkg;

  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,  // logical right, zero fill
    MODE_ASR = 2'b01,  // arithmetic right, sign fill
    MODE_RND = 2'b10,  // right shift, round half up, saturate on carry
    MODE_SHL = 2'b11   // left shift, unsigned saturation
  } mode_e;

endpackage

// File: rtl/wave_shift_core.sv
// wave_shift_core: combinational sample scaler.
//   i_data   [DATA_W]  sample captured in S1
//   i_k      [SHIFT_W] shift amount captured with the sample
//   i_mode   mode_e    shift mode captured with the sample
//   o_result [DATA_W]  scaled sample
module wave_shift_core
  import wave_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHIFT_W-1:0] i_k,
  input  mode_e              i_mode,
  output logic [DATA_W-1:0]  o_result
);

  logic [2*DATA_W-1:0] w_wide;  // left shift with room for every shifted-out bit
  logic [DATA_W:0]     w_half;
  logic [DATA_W:0]     w_sum;

  always_comb begin
    w_wide   = {{DATA_W{1'b0}}, i_data} << i_k;
    // Rounding constant 2**(k-1); only meaningful for k>0, k=0 is bypassed below.
    w_half   = (DATA_W+1)'(1) << (i_k - SHIFT_W'(1));
    w_sum    = {1'b0, i_data} + w_half;
    o_result = i_data;
    unique case (i_mode)
      MODE_LSR: o_result = i_data >> i_k;
      MODE_ASR: o_result = $signed(i_data) >>> i_k;
      MODE_RND: begin
        if (i_k == '0)
          o_result = i_data;
        else if (w_sum[DATA_W])
          o_result = '1;
        else
          o_result = DATA_W'(w_sum >> i_k);
      end
      MODE_SHL: begin
        // Any bit pushed past the MSB means overflow.
        if (|w_wide[2*DATA_W-1:DATA_W])
          o_result = '1;
        else
          o_result = w_wide[DATA_W-1:0];
      end
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/wave_shift_pipe.sv
// wave_shift_pipe: two-stage valid/ready amplitude scaler with optional shift ramp.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake, in_data sample
//   shift_n              target shift amount
//   mode                 shift mode (see wave_pkg::mode_e)
//   out_valid/out_ready  output handshake, out_data scaled sample
//   cur_shift            shift amount applied to the next accepted sample
//   ramping              cur_shift has not yet reached shift_n
module wave_shift_pipe
  import wave_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SHIFT_W = 3,
  parameter bit          RAMP    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0] shift_n,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SHIFT_W-1:0] cur_shift,
  output logic               ramping
);

  logic               r_s1_valid;
  logic [DATA_W-1:0]  r_s1_data;
  mode_e              r_s1_mode;
  logic [SHIFT_W-1:0] r_s1_k;
  logic               r_s2_valid;
  logic [DATA_W-1:0]  r_s2_data;
  logic [SHIFT_W-1:0] r_cur_shift;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_in_fire;
  logic [SHIFT_W-1:0] w_k;
  logic [DATA_W-1:0]  w_result;

  always_comb begin
    w_s2_adv  = ~r_s2_valid | out_ready;
    w_s1_adv  = ~r_s1_valid | w_s2_adv;
    w_in_fire = in_valid & w_s1_adv;
    w_k       = RAMP ? r_cur_shift : shift_n;
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign cur_shift = r_cur_shift;
  assign ramping   = (r_cur_shift != shift_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= MODE_LSR;
      r_s1_k     <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_mode <= mode_e'(mode);
        r_s1_k    <= w_k;
      end
    end
  end

  wave_shift_core #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_core (
    .i_data   (r_s1_data),
    .i_k      (r_s1_k),
    .i_mode   (r_s1_mode),
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid)
        r_s2_data <= w_result;
    end
  end

  // Ramp advances only on an accepted sample, after that sample took the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_shift <= '1;
    end else if (w_in_fire) begin
      if (RAMP) begin
        if (r_cur_shift < shift_n)
          r_cur_shift <= r_cur_shift + SHIFT_W'(1);
        else if (r_cur_shift > shift_n)
          r_cur_shift <= r_cur_shift - SHIFT_W'(1);
      end else begin
        r_cur_shift <= shift_n;
      end
    end
  end

endmodule

// File: tb/tb_wave_shift_pipe.sv
module tb_wave_shift_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [2:0]  shift_n = '0;
  logic [1:0]  mode = '0;
  logic        out_ready = 1'b1;

  logic        in_ready0, out_valid0, ramping0;
  logic [15:0] out_data0;
  logic [2:0]  cur0;
  logic        in_ready1, out_valid1, ramping1;
  logic [15:0] out_data1;
  logic [2:0]  cur1;

  always #5 clk = ~clk;

  wave_shift_pipe #(.DATA_W(16), .SHIFT_W(3), .RAMP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .shift_n(shift_n), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .cur_shift(cur0), .ramping(ramping0));

  wave_shift_pipe #(.DATA_W(16), .SHIFT_W(3), .RAMP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .shift_n(shift_n), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .cur_shift(cur1), .ramping(ramping1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference scaler written as plain integer arithmetic.
  function automatic logic [15:0] ref_scale(input logic [15:0] x, input int k, input logic [1:0] m);
    longint xv, p, v, h;
    xv = longint'(x);
    p  = 1;
    for (int i = 0; i < k; i++) p = p * 2;
    v = xv;
    case (m)
      2'd0: v = xv / p;
      2'd1: begin
        if (x[15]) v = xv - 65536;
        if (v < 0) v = -((-v + p - 1) / p);
        else       v = v / p;
      end
      2'd2: begin
        if (k == 0) v = xv;
        else begin
          h = xv + p / 2;
          v = (h >= 65536) ? 65535 : h / p;
        end
      end
      default: begin
        v = xv * p;
        if (v > 65535) v = 65535;
      end
    endcase
    return v[15:0];
  endfunction

  typedef struct {
    logic [1:0]  m;
    logic [2:0]  k;
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[17];

  task automatic do_reset(input logic [2:0] sn);
    shift_n   = sn;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid0", 32'(out_valid0), 0);
    chk("rst_out_valid1", 32'(out_valid1), 0);
    chk("rst_out_data0", 32'(out_data0), 0);
    chk("rst_cur0", 32'(cur0), 7);
    chk("rst_cur1", 32'(cur1), 7);
    chk("rst_ramping1", 32'(ramping1), 32'(sn != 3'd7));
  endtask

  // One sample through the RAMP=0 instance; lat counts clock edges from accept to out_valid.
  task automatic send_one(input logic [1:0] m, input logic [2:0] k, input logic [15:0] d,
                          output logic [15:0] got, output int lat);
    mode     = m;
    shift_n  = k;
    in_data  = d;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("one_in_ready", 32'(in_ready0), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (out_valid0) begin
        lat = c;
        got = out_data0;
        break;
      end
    end
  endtask

  // Random scoreboard state
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          cur0m, cur1m;
  int          accepted;
  bit          prev_stall;
  logic [15:0] prev_d0, prev_d1;

  task automatic rand_step(input bit allow_in);
    logic [15:0] e;
    bit exp_rdy;
    chk("cur0", 32'(cur0), 32'(cur0m));
    chk("cur1", 32'(cur1), 32'(cur1m));
    chk("ramping1", 32'(ramping1), 32'(cur1m != int'(shift_n)));
    chk("ramping0", 32'(ramping0), 32'(cur0m != int'(shift_n)));
    if (prev_stall) begin
      chk("hold_valid", 32'(out_valid0), 1);
      chk("hold_data0", 32'(out_data0), 32'(prev_d0));
      chk("hold_data1", 32'(out_data1), 32'(prev_d1));
    end
    if (q0.size() == 0) chk("idle_out_valid", 32'(out_valid0), 0);

    in_valid = allow_in && ($urandom_range(0, 3) != 0);
    in_data  = 16'($urandom);
    mode     = 2'($urandom);
    if ($urandom_range(0, 19) == 0) shift_n = 3'($urandom);
    out_ready = allow_in ? ($urandom_range(0, 2) != 0) : 1'b1;
    #1;
    exp_rdy = (q0.size() < 2) || out_ready;
    chk("in_ready0", 32'(in_ready0), 32'(exp_rdy));
    chk("in_ready1", 32'(in_ready1), 32'(exp_rdy));
    chk("valid_pair", 32'(out_valid1), 32'(out_valid0));

    if (out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        chk("extra_output", 32'(q0.size()), 1);
      end else begin
        e = q0.pop_front();
        chk("data0", 32'(out_data0), 32'(e));
        e = q1.pop_front();
        chk("data1", 32'(out_data1), 32'(e));
      end
    end
    if (in_valid && in_ready0) begin
      q0.push_back(ref_scale(in_data, int'(shift_n), mode));
      cur0m = int'(shift_n);
      q1.push_back(ref_scale(in_data, cur1m, mode));
      if (cur1m < int'(shift_n)) cur1m++;
      else if (cur1m > int'(shift_n)) cur1m--;
      accepted++;
    end
    prev_stall = out_valid0 && !out_ready;
    prev_d0 = out_data0;
    prev_d1 = out_data1;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] got;
    int          lat;
    logic [15:0] outs[10];
    int          sent, ngot;
    bit          fire;
    bit          did_rst;
    int          cyc;

    tbl[0]  = '{2'd0, 3'd3, 16'hF000, 16'h1E00};
    tbl[1]  = '{2'd1, 3'd4, 16'h8000, 16'hF800};
    tbl[2]  = '{2'd0, 3'd4, 16'h8000, 16'h0800};
    tbl[3]  = '{2'd2, 3'd2, 16'h0006, 16'h0002};
    tbl[4]  = '{2'd2, 3'd2, 16'hFFFF, 16'hFFFF};
    tbl[5]  = '{2'd2, 3'd0, 16'h1234, 16'h1234};
    tbl[6]  = '{2'd3, 3'd3, 16'h1FFF, 16'hFFF8};
    tbl[7]  = '{2'd3, 3'd3, 16'h2000, 16'hFFFF};
    tbl[8]  = '{2'd0, 3'd0, 16'hABCD, 16'hABCD};
    tbl[9]  = '{2'd1, 3'd0, 16'hABCD, 16'hABCD};
    tbl[10] = '{2'd3, 3'd0, 16'hABCD, 16'hABCD};
    tbl[11] = '{2'd1, 3'd7, 16'h8000, 16'hFF00};
    tbl[12] = '{2'd0, 3'd7, 16'hFFFF, 16'h01FF};
    tbl[13] = '{2'd3, 3'd7, 16'h01FF, 16'hFF80};
    tbl[14] = '{2'd3, 3'd7, 16'h0200, 16'hFFFF};
    tbl[15] = '{2'd2, 3'd7, 16'h0040, 16'h0001};
    tbl[16] = '{2'd2, 3'd1, 16'h0003, 16'h0002};

    @(negedge clk);
    do_reset(3'd3);
    for (int i = 0; i < 17; i++) begin
      send_one(tbl[i].m, tbl[i].k, tbl[i].din, got, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 2);
      chk($sformatf("vec%0d_data", i), 32'(got), 32'(tbl[i].dout));
    end

    // Ramp from reset value 7 down to 0, one step per accepted sample.
    do_reset(3'd0);
    mode    = 2'd0;
    in_data = 16'h8000;
    sent = 0;
    ngot = 0;
    for (int c = 0; c < 40 && ngot < 10; c++) begin
      in_valid = (sent < 10);
      #1;
      fire = in_valid && in_ready1;
      if (out_valid1) begin
        outs[ngot] = out_data1;
        ngot++;
      end
      @(negedge clk);
      if (fire) begin
        sent++;
        chk($sformatf("ramp_ramping_%0d", sent), 32'(ramping1), 32'(sent < 7));
        chk($sformatf("ramp_cur_%0d", sent), 32'(cur1), 32'((sent < 7) ? 7 - sent : 0));
      end
    end
    in_valid = 1'b0;
    chk("ramp_count", 32'(ngot), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("ramp_out_%0d", i), 32'(outs[i]), 32'(16'h8000 >> ((i < 7) ? 7 - i : 0)));

    // Random traffic with backpressure, shift changes and one mid-stream reset.
    do_reset(3'($urandom));
    cur0m = 7;
    cur1m = 7;
    accepted = 0;
    prev_stall = 1'b0;
    did_rst = 1'b0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      if (!did_rst && accepted >= 500) begin
        did_rst = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid0", 32'(out_valid0), 0);
        chk("mid_rst_valid1", 32'(out_valid1), 0);
        chk("mid_rst_cur0", 32'(cur0), 7);
        chk("mid_rst_cur1", 32'(cur1), 7);
        q0.delete();
        q1.delete();
        cur0m = 7;
        cur1m = 7;
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_valid", 32'(out_valid0), 0);
      end
      rand_step(1'b1);
      cyc++;
    end
    chk("accepted_all", 32'(accepted), 1000);
    for (int i = 0; i < 8; i++) rand_step(1'b0);
    chk("drained0", 32'(q0.size()), 0);
    chk("drained1", 32'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
